// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: fetch/decode/execute/memory/writeback sequencing.
// Define MCTRL_PERF_EN to add the cycle_cnt/instr_cnt performance counters.
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  input  logic        zero,
  input  logic        cond_true,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        instr_done,
  output logic        trap
`ifdef MCTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EX_R,
    S_EX_I,
    S_WB_ALU,
    S_ADDR_LD,
    S_ADDR_ST,
    S_MEM_RD,
    S_WB_LD,
    S_MEM_WR,
    S_BR_Z,
    S_BR_C,
    S_TRAP
  } state_t;

  localparam logic [7:0] WaitMax = 8'(MEM_WAIT_MAX);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       trap_q, trap_d;
  logic [7:0] wait_inc;
  logic       mem_state;
  logic       stalled;
  logic       timeout;

  function automatic state_t decode(input logic [10:0] op);
    state_t s;
    casez (op)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000,
      11'b10101011000,
      11'b11101011000: s = S_EX_R;
      11'b1001000100?,
      11'b1101000100?,
      11'b1011000100?,
      11'b1111000100?: s = S_EX_I;
      11'b11111000010: s = S_ADDR_LD;
      11'b11111000000: s = S_ADDR_ST;
      11'b10110100???: s = S_BR_Z;
      11'b01010100???: s = S_BR_C;
      default:         s = S_TRAP;
    endcase
    return s;
  endfunction

  assign mem_state = (state_q == S_FETCH)
                  || (state_q == S_MEM_RD)
                  || (state_q == S_MEM_WR);
  assign stalled   = mem_state && !mem_ready;
  assign wait_inc  = (wait_q == 8'hFF) ? wait_q
                                       : wait_q + 8'd1;
  // The wait that would reach the limit is the last one allowed.
  assign timeout   = stalled && (wait_inc >= WaitMax);

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    trap_d  = trap_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE:  state_d = decode(Op);
      S_EX_R:    state_d = S_WB_ALU;
      S_EX_I:    state_d = S_WB_ALU;
      S_WB_ALU:  state_d = S_FETCH;
      S_ADDR_LD: state_d = S_MEM_RD;
      S_ADDR_ST: state_d = S_MEM_WR;
      S_MEM_RD:  if (mem_ready) state_d = S_WB_LD;
      S_WB_LD:   state_d = S_FETCH;
      S_MEM_WR:  if (mem_ready) state_d = S_FETCH;
      S_BR_Z:    state_d = S_FETCH;
      S_BR_C:    state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_TRAP;
    endcase
    if (stalled) wait_d = wait_inc;
    if (timeout) begin
      state_d = S_TRAP;
      wait_d  = '0;
    end
    if (state_d == S_TRAP) trap_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
    end
  end

  // Reset forces every output low, even though the state reads FETCH.
  always_comb begin
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    Reg2Loc    = 1'b0;
    ALUSrc     = 1'b0;
    ALUOp      = 2'b00;
    instr_done = 1'b0;
    trap       = 1'b0;
    if (!reset) begin
      trap = trap_q;
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_EX_R: ALUOp = 2'b10;
        S_EX_I: begin
          ALUSrc = 1'b1;
          ALUOp  = 2'b10;
        end
        S_WB_ALU: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_ADDR_LD: ALUSrc = 1'b1;
        S_ADDR_ST: begin
          ALUSrc  = 1'b1;
          Reg2Loc = 1'b1;
        end
        S_MEM_RD: MemRead = 1'b1;
        S_WB_LD: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite   = 1'b1;
          Reg2Loc    = 1'b1;
          instr_done = mem_ready;
        end
        S_BR_Z: begin
          Reg2Loc    = 1'b1;
          ALUOp      = 2'b01;
          PCWrite    = zero;
          PCSrc      = 1'b1;
          instr_done = 1'b1;
        end
        S_BR_C: begin
          ALUOp      = 2'b01;
          PCWrite    = cond_true;
          PCSrc      = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MCTRL_PERF_EN
  logic [31:0] cyc_q, ins_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state_q != S_TRAP) cyc_q <= cyc_q + 32'd1;
      if (instr_done) ins_q <= ins_q + 32'd1;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction output sequences from an
// instruction-class model, checked every cycle, plus literal latency pins.
module tb_multicycle_ctrl;

  localparam int WMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] Op;
  logic        zero, cond_true, mem_ready;
  logic        PCWrite, PCSrc, IRWrite, MemRead, MemWrite;
  logic        RegWrite, MemtoReg, Reg2Loc, ALUSrc;
  logic [1:0]  ALUOp;
  logic        instr_done, trap;
`ifdef MCTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset(reset), .Op(Op), .zero(zero),
    .cond_true(cond_true), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .instr_done(instr_done), .trap(trap)
`ifdef MCTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  // {PCWrite,PCSrc,IRWrite,MemRead,MemWrite,RegWrite,
  //  MemtoReg,Reg2Loc,ALUSrc,ALUOp,instr_done,trap}
  logic [12:0] act;
  assign act = {PCWrite, PCSrc, IRWrite, MemRead, MemWrite,
                RegWrite, MemtoReg, Reg2Loc, ALUSrc, ALUOp,
                instr_done, trap};

  function automatic logic [12:0] ov(
    input logic pcw, pcs, irw, mrd, mwr, rw, m2r, r2l, as,
    input logic [1:0] aop, input logic dn, tr);
    return {pcw, pcs, irw, mrd, mwr, rw, m2r, r2l, as, aop, dn, tr};
  endfunction

  localparam logic [12:0] ZERO = 13'd0;
  localparam logic [12:0] TRAPV = 13'd1;

  typedef enum {C_R, C_I, C_LD, C_ST, C_BZ, C_BC, C_ILL} cls_t;

  function automatic cls_t classify(input logic [10:0] op);
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000 ||
        op == 11'b10101011000 || op == 11'b11101011000)
      return C_R;
    if (op[10:1] == 10'b1001000100 || op[10:1] == 10'b1101000100 ||
        op[10:1] == 10'b1011000100 || op[10:1] == 10'b1111000100)
      return C_I;
    if (op == 11'b11111000010) return C_LD;
    if (op == 11'b11111000000) return C_ST;
    if (op[10:3] == 8'b10110100) return C_BZ;
    if (op[10:3] == 8'b01010100) return C_BC;
    return C_ILL;
  endfunction

  logic [12:0] exp_q[$];
  string       nm_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc_since = 0;
  int mrd_cnt = 0;
  int last_lat = 0;
  int last_mrd = 0;
  int done_cnt = 0;

  always @(negedge clk) begin : cmp
    logic [12:0] e;
    string nm;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      nm = nm_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got %b want %b", nm, act, e);
      end
      if (reset) begin
        cyc_since = 0;
        mrd_cnt = 0;
      end else begin
        cyc_since++;
        if (MemRead) mrd_cnt++;
        if (instr_done) begin
          last_lat = cyc_since;
          last_mrd = mrd_cnt;
          done_cnt++;
          cyc_since = 0;
          mrd_cnt = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [10:0] rop();
    return 11'($urandom);
  endfunction

  task automatic step(input logic rs, mr, z, ct,
                      input logic [10:0] op,
                      input logic [12:0] e, input string nm);
    @(posedge clk);
    #1;
    reset = rs;
    mem_ready = mr;
    zero = z;
    cond_true = ct;
    Op = op;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
  endtask

  // Expected per-cycle outputs of one instruction from its class.
  task automatic run_instr(input logic [10:0] op, input logic z, ct,
                           input int fw, mw, input string nm);
    cls_t c;
    c = classify(op);
    for (int i = 0; i < fw; i++)
      step(0, 0, rb(), rb(), rop(),
           ov(0,0,0,1,0,0,0,0,0,2'b00,0,0), {nm, ":fwait"});
    step(0, 1, rb(), rb(), rop(),
         ov(1,0,1,1,0,0,0,0,0,2'b00,0,0), {nm, ":fetch"});
    step(0, rb(), rb(), rb(), op, ZERO, {nm, ":decode"});
    case (c)
      C_R: begin
        step(0, rb(), rb(), rb(), rop(),
             ov(0,0,0,0,0,0,0,0,0,2'b10,0,0), {nm, ":ex"});
        step(0, rb(), rb(), rb(), rop(),
             ov(0,0,0,0,0,1,0,0,0,2'b00,1,0), {nm, ":wb"});
      end
      C_I: begin
        step(0, rb(), rb(), rb(), rop(),
             ov(0,0,0,0,0,0,0,0,1,2'b10,0,0), {nm, ":ex"});
        step(0, rb(), rb(), rb(), rop(),
             ov(0,0,0,0,0,1,0,0,0,2'b00,1,0), {nm, ":wb"});
      end
      C_LD: begin
        step(0, rb(), rb(), rb(), rop(),
             ov(0,0,0,0,0,0,0,0,1,2'b00,0,0), {nm, ":addr"});
        for (int i = 0; i < mw; i++)
          step(0, 0, rb(), rb(), rop(),
               ov(0,0,0,1,0,0,0,0,0,2'b00,0,0), {nm, ":mwait"});
        step(0, 1, rb(), rb(), rop(),
             ov(0,0,0,1,0,0,0,0,0,2'b00,0,0), {nm, ":mem"});
        step(0, rb(), rb(), rb(), rop(),
             ov(0,0,0,0,0,1,1,0,0,2'b00,1,0), {nm, ":wb"});
      end
      C_ST: begin
        step(0, rb(), rb(), rb(), rop(),
             ov(0,0,0,0,0,0,0,1,1,2'b00,0,0), {nm, ":addr"});
        for (int i = 0; i < mw; i++)
          step(0, 0, rb(), rb(), rop(),
               ov(0,0,0,0,1,0,0,1,0,2'b00,0,0), {nm, ":mwait"});
        step(0, 1, rb(), rb(), rop(),
             ov(0,0,0,0,1,0,0,1,0,2'b00,1,0), {nm, ":mem"});
      end
      C_BZ:
        step(0, rb(), z, rb(), rop(),
             ov(z,1,0,0,0,0,0,1,0,2'b01,1,0), {nm, ":br"});
      C_BC:
        step(0, rb(), rb(), ct, rop(),
             ov(ct,1,0,0,0,0,0,0,0,2'b01,1,0), {nm, ":br"});
      default:
        step(0, rb(), rb(), rb(), rop(), TRAPV, {nm, ":trap"});
    endcase
    drain();
  endtask

  task automatic lat(input string nm, input int want, input int d0);
    chk({nm, "_lat"}, last_lat, want);
    chk({nm, "_done"}, done_cnt - d0, 1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      step(1, 1, rb(), rb(), rop(), ZERO, "reset");
  endtask

  initial begin : wd
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    int d0;
    reset = 1'b1;
    mem_ready = 1'b0;
    zero = 1'b0;
    cond_true = 1'b0;
    Op = '0;
    do_reset(2);

    d0 = done_cnt; run_instr(11'b10001011000, 0, 0, 0, 0, "add");
    lat("add", 4, d0);
    d0 = done_cnt; run_instr(11'b11001011000, 0, 0, 1, 0, "sub");
    lat("sub", 5, d0);
    run_instr(11'b10001010000, 0, 0, 0, 0, "and");
    run_instr(11'b10101010000, 0, 0, 2, 0, "orr");
    run_instr(11'b10101011000, 0, 0, 0, 0, "adds");
    run_instr(11'b11101011000, 0, 0, 3, 0, "subs");
    d0 = done_cnt; run_instr(11'b10010001000, 0, 0, 0, 0, "addi");
    lat("addi", 4, d0);
    run_instr(11'b11010001001, 0, 0, 0, 0, "subi");
    run_instr(11'b10110001000, 0, 0, 0, 0, "addis");
    run_instr(11'b11110001001, 0, 0, 1, 0, "subis");

    d0 = done_cnt; run_instr(11'b11111000010, 0, 0, 0, 3, "ldur");
    lat("ldur", 8, d0);
    chk("ldur_memread", last_mrd, 5);
    d0 = done_cnt; run_instr(11'b11111000010, 0, 0, 0, 0, "ldur0");
    lat("ldur0", 5, d0);
    d0 = done_cnt; run_instr(11'b11111000000, 0, 0, 0, 0, "stur");
    lat("stur", 4, d0);
    d0 = done_cnt; run_instr(11'b11111000000, 0, 0, 1, 2, "sturw");
    lat("sturw", 7, d0);

    d0 = done_cnt; run_instr(11'b10110100101, 1, 0, 0, 0, "cbz1");
    lat("cbz1", 3, d0);
    d0 = done_cnt; run_instr(11'b10110100000, 0, 0, 0, 0, "cbz0");
    lat("cbz0", 3, d0);
    d0 = done_cnt; run_instr(11'b01010100011, 0, 1, 0, 0, "bc1");
    lat("bc1", 3, d0);
    run_instr(11'b01010100111, 0, 0, 0, 0, "bc0");

    // Illegal opcode: sticky trap for 20 cycles, then reset.
    d0 = done_cnt;
    run_instr(11'b00000000000, 0, 0, 0, 0, "ill");
    for (int i = 0; i < 19; i++)
      step(0, rb(), rb(), rb(), rop(), TRAPV, "ill_hold");
    drain();
    chk("ill_nodone", done_cnt - d0, 0);
    do_reset(2);

    // Fetch timeout: 4 waiting cycles, trap on cycle 5.
    for (int i = 0; i < 4; i++)
      step(0, 0, rb(), rb(), rop(),
           ov(0,0,0,1,0,0,0,0,0,2'b00,0,0), "tmo_wait");
    for (int i = 0; i < 3; i++)
      step(0, 0, rb(), rb(), rop(), TRAPV, "tmo_trap");
    drain();
    do_reset(1);

    run_instr(11'b10001011001, 0, 0, 0, 0, "ill2");
    do_reset(1);
    run_instr(11'b11111000001, 0, 0, 0, 0, "ill3");
    do_reset(1);

    // Async reset while MemWrite is asserted.
    step(0, 1, 0, 0, rop(),
         ov(1,0,1,1,0,0,0,0,0,2'b00,0,0), "rst_fetch");
    step(0, 0, 0, 0, 11'b11111000000, ZERO, "rst_dec");
    step(0, 0, 0, 0, rop(),
         ov(0,0,0,0,0,0,0,1,1,2'b00,0,0), "rst_addr");
    step(0, 0, 0, 0, rop(),
         ov(0,0,0,0,1,0,0,1,0,2'b00,0,0), "rst_memwr");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_memwrite", int'(MemWrite), 0);
    chk("rst_outs", int'(act), 0);
`ifdef MCTRL_PERF_EN
    chk("rst_cycle_cnt", int'(cycle_cnt), 0);
    chk("rst_instr_cnt", int'(instr_cnt), 0);
`endif
    step(1, 1, 0, 0, rop(), ZERO, "rst_hold");
    d0 = done_cnt;
    run_instr(11'b10001011000, 0, 0, 0, 0, "post_rst");
    lat("post_rst", 4, d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
